// File: rtl/seg7_pkg.sv
// Shared types and 7-segment decode table for the multi-digit BCD counter
// and its display scan.
package seg7_pkg;

   typedef logic [3:0] bcd_t;

   // Active-high segments, bit0 = a ... bit6 = g.
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic bcd_t bcd_clamp(input bcd_t d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   function automatic logic [6:0] seg_decode(input bcd_t d);
      logic [6:0] s;
      s = SEG_BLANK;
      if (d <= 4'd9) s = SEG_DIGIT[d];
      return s;
   endfunction

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexed display scan: one shared segment bus, one-hot digit
// enables, optional leading-zero blanking. Outputs are registered together.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_W   = 10,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   count_bcd,
   output logic [6:0]            segments,
   output logic [DIGITS-1:0]     digit_sel
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [SCAN_W-1:0] scan_q, scan_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [6:0]        segments_q, segments_d;
   logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
   bcd_t              cur_digit;
   logic              upper_nz;

   always_comb begin
      scan_d      = scan_q + SCAN_W'(1);
      index_d     = index_q;
      cur_digit   = '0;
      upper_nz    = 1'b0;
      digit_sel_d = '0;

      if (&scan_q)
         index_d = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);

      // upper_nz: any non-zero digit at or above the one being shown
      for (int i = 0; i < DIGITS; i++) begin
         if (i == int'(index_q)) begin
            cur_digit      = count_bcd[i*4 +: 4];
            digit_sel_d[i] = 1'b1;
         end
         if ((i >= int'(index_q)) && (count_bcd[i*4 +: 4] != 4'd0))
            upper_nz = 1'b1;
      end

      segments_d = seg_decode(cur_digit);
      if ((BLANK_LZ != 0) && (index_q != '0) && !upper_nz)
         segments_d = SEG_BLANK;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_q      <= '0;
         index_q     <= '0;
         segments_q  <= SEG_BLANK;
         digit_sel_q <= '0;
      end else begin
         scan_q      <= scan_d;
         index_q     <= index_d;
         segments_q  <= segments_d;
         digit_sel_q <= digit_sel_d;
      end
   end

   assign segments  = segments_q;
   assign digit_sel = digit_sel_q;

endmodule

// File: rtl/seg7_multi_counter.sv
// Programmable-prescaler BCD up/down counter with parallel load, driving a
// multiplexed 7-segment display through seg7_scan.
module seg7_multi_counter
   import seg7_pkg::*;
#(
   parameter int          DIGITS          = 4,
   parameter int          PRESCALE_W      = 24,
   parameter int unsigned DEFAULT_COMPARE = 9_999_999,
   parameter int          SCAN_W          = 10,
   parameter int          BLANK_LZ        = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PRESCALE_W-1:0] compare_in,
   input  logic                  enable,
   input  logic                  up_down,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic                  tick,
   output logic                  wrap,
   output logic [6:0]            segments,
   output logic [DIGITS-1:0]     digit_sel
);

   localparam int CW = 4 * DIGITS;
   localparam logic [PRESCALE_W-1:0] DEF_C = PRESCALE_W'(DEFAULT_COMPARE);

   logic [PRESCALE_W-1:0] p_q, p_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  tick_q, tick_d;
   logic                  wrap_q, wrap_d;
   logic [PRESCALE_W-1:0] c_eff;
   logic [CW:0]           step;

   // Ripple BCD step; MSB of the result is the carry/borrow out of the top digit.
   function automatic logic [CW:0] bcd_step(input logic [CW-1:0] v, input logic up);
      logic [CW-1:0] r;
      logic          c;
      bcd_t          d;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[i*4 +: 4];
         if (c) begin
            if (up) begin
               if (d == 4'd9) r[i*4 +: 4] = 4'd0;
               else begin
                  r[i*4 +: 4] = d + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (d == 4'd0) r[i*4 +: 4] = 4'd9;
               else begin
                  r[i*4 +: 4] = d - 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return {c, r};
   endfunction

   function automatic logic [CW-1:0] clamp_all(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++)
         r[i*4 +: 4] = bcd_clamp(v[i*4 +: 4]);
      return r;
   endfunction

   always_comb begin
      c_eff   = (compare_in == '0) ? DEF_C : compare_in;
      p_d     = p_q;
      count_d = count_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      step    = '0;

      // >= rather than == so a compare lowered below P ends the period at once
      if (load) begin
         count_d = clamp_all(load_value);
         p_d     = '0;
      end else if (enable) begin
         if (p_q >= c_eff) begin
            p_d     = '0;
            tick_d  = 1'b1;
            step    = bcd_step(count_q, up_down);
            count_d = step[CW-1:0];
            wrap_d  = step[CW];
         end else begin
            p_d = p_q + PRESCALE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_q     <= '0;
         count_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         p_q     <= p_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count_bcd = count_q;
   assign tick      = tick_q;
   assign wrap      = wrap_q;

   seg7_scan #(
      .DIGITS   (DIGITS),
      .SCAN_W   (SCAN_W),
      .BLANK_LZ (BLANK_LZ)
   ) u_scan (
      .clk       (clk),
      .reset     (reset),
      .count_bcd (count_q),
      .segments  (segments),
      .digit_sel (digit_sel)
   );

endmodule

// File: tb/tb_seg7_multi_counter.sv
// Scoreboard bench for seg7_multi_counter: expected tick results and scan
// frames are queued when stimulus is applied and popped as the DUT responds.
module tb_seg7_multi_counter;

   logic        clk;
   logic        reset;
   logic [23:0] compare_in;
   logic        enable;
   logic        up_down;
   logic        load;
   logic [15:0] load_value;
   logic [15:0] count_bcd;
   logic        tick;
   logic        wrap;
   logic [6:0]  segments;
   logic [3:0]  digit_sel;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] cnt;
      logic        wr;
      int          gap;
   } tick_exp_t;

   typedef struct {
      logic [3:0] sel;
      logic [6:0] seg;
   } scan_exp_t;

   tick_exp_t tq[$];
   scan_exp_t sq[$];

   seg7_multi_counter #(
      .DIGITS          (4),
      .PRESCALE_W      (24),
      .DEFAULT_COMPARE (6),
      .SCAN_W          (2),
      .BLANK_LZ        (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .compare_in (compare_in),
      .enable     (enable),
      .up_down    (up_down),
      .load       (load),
      .load_value (load_value),
      .count_bcd  (count_bcd),
      .tick       (tick),
      .wrap       (wrap),
      .segments   (segments),
      .digit_sel  (digit_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_tick(input int budget, output int cycles, output bit ok);
      cycles = 0;
      ok     = 1'b0;
      while ((cycles < budget) && !ok) begin
         @(negedge clk);
         cycles++;
         if (tick === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic drive_load(input logic [15:0] v);
      load_value = v;
      load       = 1'b1;
      @(negedge clk);
      load       = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL rst_count got=%h exp=0000", count_bcd); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", tick); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap got=%b exp=0", wrap); end
      checks++; if (segments !== 7'h00) begin errors++; $display("FAIL rst_segments got=%h exp=00", segments); end
      checks++; if (digit_sel !== 4'b0000) begin errors++; $display("FAIL rst_digit_sel got=%b exp=0000", digit_sel); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (digit_sel !== 4'b0001) begin errors++; $display("FAIL first_digit_sel got=%b exp=0001", digit_sel); end
      checks++; if (segments !== 7'h3F) begin errors++; $display("FAIL first_segments got=%h exp=3F", segments); end
   endtask

   task automatic test_count_up;
      int cyc; bit ok; tick_exp_t e;
      compare_in = 24'd4; up_down = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 3; k++) tq.push_back('{cnt: 16'(k), wr: 1'b0, gap: 5});
      while (tq.size() > 0) begin
         e = tq.pop_front();
         wait_tick(20, cyc, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL up_tick_timeout waited=%0d exp_gap=%0d", cyc, e.gap); end
         else begin
            if (cyc !== e.gap) begin errors++; $display("FAIL up_period got=%0d exp=%0d", cyc, e.gap); end
            checks++; if (count_bcd !== e.cnt) begin errors++; $display("FAIL up_count got=%h exp=%h", count_bcd, e.cnt); end
            checks++; if (wrap !== e.wr) begin errors++; $display("FAIL up_wrap got=%b exp=%b", wrap, e.wr); end
         end
      end
      @(negedge clk);
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_width got=%b exp=0", tick); end
      enable = 1'b0;
   endtask

   task automatic test_wrap_up;
      int cyc; bit ok; tick_exp_t e;
      compare_in = 24'd1; up_down = 1'b1; enable = 1'b1;
      drive_load(16'h9998);
      checks++; if (count_bcd !== 16'h9998) begin errors++; $display("FAIL wrapup_load got=%h exp=9998", count_bcd); end
      tq.push_back('{cnt: 16'h9999, wr: 1'b0, gap: 2});
      tq.push_back('{cnt: 16'h0000, wr: 1'b1, gap: 2});
      while (tq.size() > 0) begin
         e = tq.pop_front();
         wait_tick(10, cyc, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL wrapup_timeout waited=%0d exp_gap=%0d", cyc, e.gap); end
         else begin
            if (cyc !== e.gap) begin errors++; $display("FAIL wrapup_period got=%0d exp=%0d", cyc, e.gap); end
            checks++; if (count_bcd !== e.cnt) begin errors++; $display("FAIL wrapup_count got=%h exp=%h", count_bcd, e.cnt); end
            checks++; if (wrap !== e.wr) begin errors++; $display("FAIL wrapup_wrap got=%b exp=%b", wrap, e.wr); end
         end
      end
      @(negedge clk);
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_width got=%b exp=0", wrap); end
      enable = 1'b0;
   endtask

   task automatic test_down;
      int cyc; bit ok; tick_exp_t e;
      compare_in = 24'd1; up_down = 1'b0; enable = 1'b1;
      drive_load(16'h0000);
      tq.push_back('{cnt: 16'h9999, wr: 1'b1, gap: 2});
      tq.push_back('{cnt: 16'h9998, wr: 1'b0, gap: 2});
      while (tq.size() > 0) begin
         e = tq.pop_front();
         wait_tick(10, cyc, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL down_timeout waited=%0d exp_gap=%0d", cyc, e.gap); end
         else begin
            if (cyc !== e.gap) begin errors++; $display("FAIL down_period got=%0d exp=%0d", cyc, e.gap); end
            checks++; if (count_bcd !== e.cnt) begin errors++; $display("FAIL down_count got=%h exp=%h", count_bcd, e.cnt); end
            checks++; if (wrap !== e.wr) begin errors++; $display("FAIL down_wrap got=%b exp=%b", wrap, e.wr); end
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_load_clamp;
      int cyc; bit ok; tick_exp_t e;
      compare_in = 24'd3; up_down = 1'b1; enable = 1'b1;
      drive_load(16'h0000);
      repeat (2) @(negedge clk);
      drive_load(16'hA5F3);
      checks++; if (count_bcd !== 16'h9593) begin errors++; $display("FAIL clamp_count got=%h exp=9593", count_bcd); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL clamp_tick got=%b exp=0", tick); end
      tq.push_back('{cnt: 16'h9594, wr: 1'b0, gap: 4});
      while (tq.size() > 0) begin
         e = tq.pop_front();
         wait_tick(10, cyc, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL clamp_timeout waited=%0d exp_gap=%0d", cyc, e.gap); end
         else begin
            if (cyc !== e.gap) begin errors++; $display("FAIL clamp_p_reset got=%0d exp=%0d", cyc, e.gap); end
            checks++; if (count_bcd !== e.cnt) begin errors++; $display("FAIL clamp_next got=%h exp=%h", count_bcd, e.cnt); end
         end
      end
      compare_in = 24'd1;
      drive_load(16'h0100);
      @(negedge clk);
      drive_load(16'h0200);
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL collide_tick got=%b exp=0", tick); end
      checks++; if (count_bcd !== 16'h0200) begin errors++; $display("FAIL collide_count got=%h exp=0200", count_bcd); end
      tq.push_back('{cnt: 16'h0201, wr: 1'b0, gap: 2});
      while (tq.size() > 0) begin
         e = tq.pop_front();
         wait_tick(10, cyc, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL collide_timeout waited=%0d exp_gap=%0d", cyc, e.gap); end
         else begin
            if (cyc !== e.gap) begin errors++; $display("FAIL collide_period got=%0d exp=%0d", cyc, e.gap); end
            checks++; if (count_bcd !== e.cnt) begin errors++; $display("FAIL collide_next got=%h exp=%h", count_bcd, e.cnt); end
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_default_compare;
      int cyc; bit ok; tick_exp_t e;
      compare_in = 24'd0; up_down = 1'b1; enable = 1'b1;
      drive_load(16'h0000);
      tq.push_back('{cnt: 16'h0001, wr: 1'b0, gap: 7});
      while (tq.size() > 0) begin
         e = tq.pop_front();
         wait_tick(20, cyc, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL defc_timeout waited=%0d exp_gap=%0d", cyc, e.gap); end
         else begin
            if (cyc !== e.gap) begin errors++; $display("FAIL defc_period got=%0d exp=%0d", cyc, e.gap); end
            checks++; if (count_bcd !== e.cnt) begin errors++; $display("FAIL defc_count got=%h exp=%h", count_bcd, e.cnt); end
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_scan;
      logic [15:0] pat [3];
      logic [6:0]  segx [3][4];
      logic [3:0]  prev;
      bit          found;
      scan_exp_t   e;
      pat[0] = 16'h0042; segx[0][0] = 7'h5B; segx[0][1] = 7'h66; segx[0][2] = 7'h00; segx[0][3] = 7'h00;
      pat[1] = 16'h1002; segx[1][0] = 7'h5B; segx[1][1] = 7'h3F; segx[1][2] = 7'h3F; segx[1][3] = 7'h06;
      pat[2] = 16'h0000; segx[2][0] = 7'h3F; segx[2][1] = 7'h00; segx[2][2] = 7'h00; segx[2][3] = 7'h00;
      enable = 1'b0;
      for (int p = 0; p < 3; p++) begin
         drive_load(pat[p]);
         repeat (2) @(negedge clk);
         prev  = digit_sel;
         found = 1'b0;
         for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clk);
            if ((prev === 4'b1000) && (digit_sel === 4'b0001)) found = 1'b1;
            prev = digit_sel;
         end
         checks++;
         if (!found) begin errors++; $display("FAIL scan_sync_timeout pattern=%h sel=%b", pat[p], digit_sel); end
         else begin
            for (int d = 0; d < 4; d++)
               for (int h = 0; h < 4; h++) sq.push_back('{sel: 4'b0001 << d, seg: segx[p][d]});
            for (int j = 0; sq.size() > 0; j++) begin
               if (j > 0) @(negedge clk);
               e = sq.pop_front();
               checks++; if (digit_sel !== e.sel) begin errors++; $display("FAIL scan_sel pattern=%h step=%0d got=%b exp=%b", pat[p], j, digit_sel, e.sel); end
               checks++; if (segments !== e.seg) begin errors++; $display("FAIL scan_seg pattern=%h step=%0d got=%h exp=%h", pat[p], j, segments, e.seg); end
            end
         end
      end
   endtask

   task automatic test_compare_change;
      int cyc; bit ok; bit seen; tick_exp_t e;
      compare_in = 24'd200; up_down = 1'b1; enable = 1'b1;
      drive_load(16'h0000);
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (tick === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cmp_early_tick got=%b exp=0", seen); end
      compare_in = 24'd50;
      tq.push_back('{cnt: 16'h0001, wr: 1'b0, gap: 1});
      while (tq.size() > 0) begin
         e = tq.pop_front();
         wait_tick(60, cyc, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL cmp_timeout waited=%0d exp_gap=%0d", cyc, e.gap); end
         else begin
            if (cyc !== e.gap) begin errors++; $display("FAIL cmp_lowered got=%0d exp=%0d", cyc, e.gap); end
            checks++; if (count_bcd !== e.cnt) begin errors++; $display("FAIL cmp_count got=%h exp=%h", count_bcd, e.cnt); end
         end
      end
   endtask

   task automatic test_reset_mid;
      int cyc; bit ok; tick_exp_t e;
      compare_in = 24'd10; up_down = 1'b1; enable = 1'b1;
      drive_load(16'h1234);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL midrst_count got=%h exp=0000", count_bcd); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got=%b exp=0", tick); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL midrst_wrap got=%b exp=0", wrap); end
      checks++; if (segments !== 7'h00) begin errors++; $display("FAIL midrst_segments got=%h exp=00", segments); end
      checks++; if (digit_sel !== 4'b0000) begin errors++; $display("FAIL midrst_digit_sel got=%b exp=0000", digit_sel); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      tq.push_back('{cnt: 16'h0001, wr: 1'b0, gap: 11});
      while (tq.size() > 0) begin
         e = tq.pop_front();
         wait_tick(30, cyc, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL midrst_timeout waited=%0d exp_gap=%0d", cyc, e.gap); end
         else begin
            if (cyc !== e.gap) begin errors++; $display("FAIL midrst_period got=%0d exp=%0d", cyc, e.gap); end
            checks++; if (count_bcd !== e.cnt) begin errors++; $display("FAIL midrst_next got=%h exp=%h", count_bcd, e.cnt); end
         end
      end
      enable = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      compare_in = '0;
      enable     = 1'b0;
      up_down    = 1'b1;
      load       = 1'b0;
      load_value = '0;
      test_reset();
      test_count_up();
      test_wrap_up();
      test_down();
      test_load_clamp();
      test_default_compare();
      test_scan();
      test_compare_change();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
